// File: rtl/commit_queue_pkg.sv
// Shared definitions for the commit queue: FSM state codes and entry sizing.
package commit_queue_pkg;

  // Commit FSM state codes
  localparam logic StRun     = 1'b0;
  localparam logic StCsrWait = 1'b1;

  // Packed entry layout, MSB first:
  // wena | waddr | wdata | is_csr | csr_op | csr_wena | csr_waddr | csr_wdata [| pc | inst]
  function automatic int unsigned entry_width(input int unsigned xlen,
                                               input int unsigned reg_aw,
                                               input int unsigned csr_opw,
                                               input bit          trace);
    return 1 + reg_aw + xlen + 1 + csr_opw + 1 + xlen + xlen + (trace ? 2 * xlen : 0);
  endfunction

endpackage

// File: rtl/commit_queue_mem.sv
// Entry storage for the commit queue: one synchronous write port, one combinational read port.
module commit_queue_mem #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic                       clock,
  input  logic                       we_i,
  input  logic [$clog2(DEPTH)-1:0]   waddr_i,
  input  logic [WIDTH-1:0]           wdata_i,
  input  logic [$clog2(DEPTH)-1:0]   raddr_i,
  output logic [WIDTH-1:0]           rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // Write the pushed entry; contents need no reset since occupancy gates every read
  always_ff @(posedge clock) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/commit_queue.sv
// In-order commit queue between memory stage and GPR/CSR writeback.
// Optional feature macro: COMMIT_TRACE_EN adds per-entry pc/inst and commit_pc_o/commit_inst_o.
module commit_queue
  import commit_queue_pkg::*;
#(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned XLEN    = 32,
  parameter int unsigned REG_AW  = 5,
  parameter int unsigned CSR_OPW = 8
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       flush_i,
  input  logic                       valid_pre_i,
  output logic                       ready_pre_o,
  input  logic [XLEN-1:0]            pc_i,
  input  logic [XLEN-1:0]            inst_i,
  input  logic                       wsel_i,
  input  logic                       wena_i,
  input  logic [REG_AW-1:0]          waddr_i,
  input  logic [XLEN-1:0]            alu_result_i,
  input  logic [XLEN-1:0]            mem_result_i,
  input  logic [CSR_OPW-1:0]         csr_op_i,
  input  logic                       csr_wena_i,
  input  logic [XLEN-1:0]            csr_waddr_i,
  input  logic [XLEN-1:0]            csr_wdata_i,
  input  logic                       commit_ready_i,
  output logic                       commit_valid_o,
  output logic                       commit_csr_o,
  output logic                       wena_o,
  output logic [REG_AW-1:0]          waddr_o,
  output logic [XLEN-1:0]            wdata_o,
  output logic [CSR_OPW-1:0]         csr_op_o,
  output logic                       csr_wena_o,
  output logic [XLEN-1:0]            csr_waddr_o,
  output logic [XLEN-1:0]            csr_wdata_o,
`ifdef COMMIT_TRACE_EN
  output logic [XLEN-1:0]            commit_pc_o,
  output logic [XLEN-1:0]            commit_inst_o,
`endif
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       empty_o,
  output logic                       full_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
`ifdef COMMIT_TRACE_EN
  localparam bit Trace = 1'b1;
`else
  localparam bit Trace = 1'b0;
`endif
  localparam int unsigned EW = entry_width(XLEN, REG_AW, CSR_OPW, Trace);

  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          state_q, state_d;
  logic          push, pop, full, empty;

  logic [EW-1:0] wr_entry, rd_entry;
  logic [XLEN-1:0] wdata_in;

  // Head entry fields
  logic               h_wena, h_is_csr, h_csr_wena;
  logic [REG_AW-1:0]  h_waddr;
  logic [XLEN-1:0]    h_wdata, h_csr_waddr, h_csr_wdata;
  logic [CSR_OPW-1:0] h_csr_op;

  assign wdata_in = wsel_i ? mem_result_i : alu_result_i;

`ifdef COMMIT_TRACE_EN
  logic [XLEN-1:0] h_pc, h_inst;
  assign wr_entry = {wena_i, waddr_i, wdata_in, |csr_op_i, csr_op_i, csr_wena_i,
                     csr_waddr_i, csr_wdata_i, pc_i, inst_i};
  assign {h_wena, h_waddr, h_wdata, h_is_csr, h_csr_op, h_csr_wena,
          h_csr_waddr, h_csr_wdata, h_pc, h_inst} = rd_entry;
`else
  logic unused_trace;
  assign unused_trace = ^{pc_i, inst_i};
  assign wr_entry = {wena_i, waddr_i, wdata_in, |csr_op_i, csr_op_i, csr_wena_i,
                     csr_waddr_i, csr_wdata_i};
  assign {h_wena, h_waddr, h_wdata, h_is_csr, h_csr_op, h_csr_wena,
          h_csr_waddr, h_csr_wdata} = rd_entry;
`endif

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);

  // Handshake: a pop frees a slot the same cycle, so a full queue may still accept
  assign pop         = !empty && commit_ready_i && (state_q == StRun) && !flush_i;
  assign ready_pre_o = !flush_i && (!full || pop);
  assign push        = valid_pre_i && ready_pre_o;

  commit_queue_mem #(
    .DEPTH (DEPTH),
    .WIDTH (EW)
  ) u_mem (
    .clock   (clock),
    .we_i    (push),
    .waddr_i (wr_ptr_q),
    .wdata_i (wr_entry),
    .raddr_i (rd_ptr_q),
    .rdata_o (rd_entry)
  );

  // Pointer, occupancy and FSM next state; flush wins over everything
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    state_d  = StRun;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      if (push && !pop)      count_d = count_q + CW'(1);
      else if (pop && !push) count_d = count_q - CW'(1);
      // CSR retire forces a single bubble cycle before the next retire
      if (state_q == StRun && pop && h_is_csr) state_d = StCsrWait;
    end
  end

  // Pointer, occupancy and FSM state registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      state_q  <= StRun;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      state_q  <= state_d;
    end
  end

  logic               commit_valid_q, commit_valid_d, commit_csr_q, commit_csr_d;
  logic               wena_q, wena_d, csr_wena_q, csr_wena_d;
  logic [REG_AW-1:0]  waddr_q, waddr_d;
  logic [XLEN-1:0]    wdata_q, wdata_d, csr_waddr_q, csr_waddr_d, csr_wdata_q, csr_wdata_d;
  logic [CSR_OPW-1:0] csr_op_q, csr_op_d;

  // Output next state: strobes pulse on pop only, data fields hold otherwise
  always_comb begin
    commit_valid_d = 1'b0;
    commit_csr_d   = 1'b0;
    wena_d         = 1'b0;
    csr_wena_d     = 1'b0;
    waddr_d        = waddr_q;
    wdata_d        = wdata_q;
    csr_op_d       = csr_op_q;
    csr_waddr_d    = csr_waddr_q;
    csr_wdata_d    = csr_wdata_q;
    if (pop) begin
      commit_valid_d = 1'b1;
      commit_csr_d   = h_is_csr;
      wena_d         = h_wena && (h_waddr != '0);
      csr_wena_d     = h_csr_wena;
      waddr_d        = h_waddr;
      wdata_d        = h_wdata;
      csr_op_d       = h_csr_op;
      csr_waddr_d    = h_csr_waddr;
      csr_wdata_d    = h_csr_wdata;
    end
  end

  // Output registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      commit_valid_q <= 1'b0;
      commit_csr_q   <= 1'b0;
      wena_q         <= 1'b0;
      csr_wena_q     <= 1'b0;
      waddr_q        <= '0;
      wdata_q        <= '0;
      csr_op_q       <= '0;
      csr_waddr_q    <= '0;
      csr_wdata_q    <= '0;
    end else begin
      commit_valid_q <= commit_valid_d;
      commit_csr_q   <= commit_csr_d;
      wena_q         <= wena_d;
      csr_wena_q     <= csr_wena_d;
      waddr_q        <= waddr_d;
      wdata_q        <= wdata_d;
      csr_op_q       <= csr_op_d;
      csr_waddr_q    <= csr_waddr_d;
      csr_wdata_q    <= csr_wdata_d;
    end
  end

`ifdef COMMIT_TRACE_EN
  logic [XLEN-1:0] pc_q, pc_d, inst_q, inst_d;

  // Trace next state: loaded with the other outputs on pop
  always_comb begin
    pc_d   = pop ? h_pc : pc_q;
    inst_d = pop ? h_inst : inst_q;
  end

  // Trace registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pc_q   <= '0;
      inst_q <= '0;
    end else begin
      pc_q   <= pc_d;
      inst_q <= inst_d;
    end
  end

  assign commit_pc_o   = pc_q;
  assign commit_inst_o = inst_q;
`endif

  assign commit_valid_o = commit_valid_q;
  assign commit_csr_o   = commit_csr_q;
  assign wena_o         = wena_q;
  assign csr_wena_o     = csr_wena_q;
  assign waddr_o        = waddr_q;
  assign wdata_o        = wdata_q;
  assign csr_op_o       = csr_op_q;
  assign csr_waddr_o    = csr_waddr_q;
  assign csr_wdata_o    = csr_wdata_q;
  assign count_o        = count_q;
  assign empty_o        = empty;
  assign full_o         = full;

endmodule

// File: tb/tb_commit_queue.sv
// Self-checking bench for commit_queue: queue-based reference model plus directed vectors.
module tb_commit_queue;

  localparam int D = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        flush = 1'b0, valid = 1'b0, wsel = 1'b0, wena = 1'b0;
  logic        csr_wena = 1'b0, commit_ready = 1'b0;
  logic [4:0]  waddr = '0;
  logic [7:0]  csr_op = '0;
  logic [31:0] pc = '0, inst = '0, alu = '0, mem = '0, csr_waddr = '0, csr_wdata = '0;

  logic        ready_pre_o, commit_valid_o, commit_csr_o, wena_o, csr_wena_o;
  logic        empty_o, full_o;
  logic [4:0]  waddr_o;
  logic [7:0]  csr_op_o;
  logic [31:0] wdata_o, csr_waddr_o, csr_wdata_o;
  logic [2:0]  count_o;
`ifdef COMMIT_TRACE_EN
  logic [31:0] commit_pc_o, commit_inst_o;
`endif

  always #5 clock = ~clock;

  commit_queue dut (
    .clock          (clock),
    .reset          (reset),
    .flush_i        (flush),
    .valid_pre_i    (valid),
    .ready_pre_o    (ready_pre_o),
    .pc_i           (pc),
    .inst_i         (inst),
    .wsel_i         (wsel),
    .wena_i         (wena),
    .waddr_i        (waddr),
    .alu_result_i   (alu),
    .mem_result_i   (mem),
    .csr_op_i       (csr_op),
    .csr_wena_i     (csr_wena),
    .csr_waddr_i    (csr_waddr),
    .csr_wdata_i    (csr_wdata),
    .commit_ready_i (commit_ready),
    .commit_valid_o (commit_valid_o),
    .commit_csr_o   (commit_csr_o),
    .wena_o         (wena_o),
    .waddr_o        (waddr_o),
    .wdata_o        (wdata_o),
    .csr_op_o       (csr_op_o),
    .csr_wena_o     (csr_wena_o),
    .csr_waddr_o    (csr_waddr_o),
    .csr_wdata_o    (csr_wdata_o),
`ifdef COMMIT_TRACE_EN
    .commit_pc_o    (commit_pc_o),
    .commit_inst_o  (commit_inst_o),
`endif
    .count_o        (count_o),
    .empty_o        (empty_o),
    .full_o         (full_o)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic        wena;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        is_csr;
    logic [7:0]  csr_op;
    logic        csr_wena;
    logic [31:0] csr_waddr, csr_wdata, pc, inst;
  } ent_t;

  ent_t mq[$];
  bit   bubble = 0;   // a CSR retired last cycle, so nothing may retire this cycle
  logic        m_valid = 0, m_csr = 0, m_wena = 0, m_csr_wena = 0;
  logic [4:0]  m_waddr = '0;
  logic [7:0]  m_csr_op = '0;
  logic [31:0] m_wdata = '0, m_csr_waddr = '0, m_csr_wdata = '0, m_pc = '0, m_inst = '0;

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      mq.delete();
      bubble = 0;
      m_valid = 0; m_csr = 0; m_wena = 0; m_csr_wena = 0;
      m_waddr = '0; m_wdata = '0; m_csr_op = '0; m_csr_waddr = '0; m_csr_wdata = '0;
      m_pc = '0; m_inst = '0;
    end else if (flush) begin
      mq.delete();
      bubble = 0;
      m_valid = 0; m_csr = 0; m_wena = 0; m_csr_wena = 0;
    end else begin
      bit   do_pop, do_push;
      ent_t e, n;
      do_pop  = (mq.size() > 0) && commit_ready && !bubble;
      do_push = valid && ((mq.size() < D) || do_pop);
      bubble = 0;
      m_valid = 0; m_csr = 0; m_wena = 0; m_csr_wena = 0;
      if (do_pop) begin
        e = mq.pop_front();
        m_valid = 1;
        m_csr = e.is_csr;
        m_wena = e.wena && (e.waddr != 0);
        m_csr_wena = e.csr_wena;
        m_waddr = e.waddr; m_wdata = e.wdata; m_csr_op = e.csr_op;
        m_csr_waddr = e.csr_waddr; m_csr_wdata = e.csr_wdata;
        m_pc = e.pc; m_inst = e.inst;
        bubble = e.is_csr;
      end
      if (do_push) begin
        n.wena = wena; n.waddr = waddr; n.wdata = wsel ? mem : alu;
        n.is_csr = (csr_op != 0); n.csr_op = csr_op; n.csr_wena = csr_wena;
        n.csr_waddr = csr_waddr; n.csr_wdata = csr_wdata; n.pc = pc; n.inst = inst;
        mq.push_back(n);
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge
  always @(negedge clock) begin
    bit exp_ready;
    exp_ready = !flush && ((mq.size() < D) || ((mq.size() > 0) && commit_ready && !bubble));
    if (!reset) exp_ready = !flush;
    chk("m_ready_pre", ready_pre_o, exp_ready);
    chk("m_commit_valid", commit_valid_o, m_valid);
    chk("m_commit_csr", commit_csr_o, m_csr);
    chk("m_wena", wena_o, m_wena);
    chk("m_waddr", waddr_o, m_waddr);
    chk("m_wdata", wdata_o, m_wdata);
    chk("m_csr_op", csr_op_o, m_csr_op);
    chk("m_csr_wena", csr_wena_o, m_csr_wena);
    chk("m_csr_waddr", csr_waddr_o, m_csr_waddr);
    chk("m_csr_wdata", csr_wdata_o, m_csr_wdata);
    chk("m_count", count_o, mq.size());
    chk("m_empty", empty_o, mq.size() == 0);
    chk("m_full", full_o, mq.size() == D);
`ifdef COMMIT_TRACE_EN
    chk("m_pc", commit_pc_o, m_pc);
    chk("m_inst", commit_inst_o, m_inst);
`endif
  end

  // ---------------- directed stimulus ----------------
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    valid = 0; wena = 0; wsel = 0; waddr = '0; csr_op = '0; csr_wena = 0;
    alu = '0; mem = '0; csr_waddr = '0; csr_wdata = '0;
  endtask

  task automatic set_push(input logic [4:0] wa, input logic ws, input logic [31:0] a,
                          input logic [31:0] m, input logic we);
    idle();
    valid = 1; waddr = wa; wsel = ws; alu = a; mem = m; wena = we;
    pc = a + 32'h1000; inst = a ^ 32'h00ff_00ff;
  endtask

  initial begin
    // Reset state
    step(); step();
    chk("rst_count", count_o, 0);
    chk("rst_empty", empty_o, 1);
    chk("rst_ready", ready_pre_o, 1);
    chk("rst_valid", commit_valid_o, 0);
    chk("rst_wdata", wdata_o, 0);
    reset = 1;
    step();

    // 1: single push retires on the following edge
    commit_ready = 1;
    set_push(5'd5, 1'b0, 32'h1234, 32'h0, 1'b1);
    step();
    idle();
    step();
    chk("t1_valid", commit_valid_o, 1);
    chk("t1_wena", wena_o, 1);
    chk("t1_waddr", waddr_o, 5);
    chk("t1_wdata", wdata_o, 32'h1234);
    step();
    chk("t1_pulse_end", commit_valid_o, 0);
    chk("t1_hold", wdata_o, 32'h1234);

    // 2: fill with writeback stalled, then drain in order
    commit_ready = 0;
    for (int i = 0; i < 5; i++) begin
      set_push(5'(i + 1), 1'b0, 32'h100 + i, 32'h0, 1'b1);
      #1;
      chk("t2_ready", ready_pre_o, i < 4);
      step();
    end
    idle();
    chk("t2_full", full_o, 1);
    chk("t2_count", count_o, 4);
    commit_ready = 1;
    for (int j = 0; j < 4; j++) begin
      step();
      chk("t2_valid", commit_valid_o, 1);
      chk("t2_order", wdata_o, 32'h100 + j);
    end
    step();
    chk("t2_empty", empty_o, 1);

    // 3: CSR commit followed by a GPR commit after one bubble
    idle();
    valid = 1; csr_op = 8'h01; csr_wena = 1; csr_waddr = 32'h300; csr_wdata = 32'habc;
    step();
    set_push(5'd7, 1'b0, 32'h77, 32'h0, 1'b1);
    step();
    idle();
    chk("t3_csr", commit_csr_o, 1);
    chk("t3_csr_wena", csr_wena_o, 1);
    chk("t3_csr_waddr", csr_waddr_o, 32'h300);
    step();
    chk("t3_bubble", commit_valid_o, 0);
    step();
    chk("t3_gpr_valid", commit_valid_o, 1);
    chk("t3_gpr_csr", commit_csr_o, 0);
    chk("t3_gpr_waddr", waddr_o, 7);

    // 4: x0 destination suppresses the GPR strobe, load data selected
    set_push(5'd0, 1'b1, 32'hbeef, 32'hdead, 1'b1);
    step();
    idle();
    step();
    chk("t4_valid", commit_valid_o, 1);
    chk("t4_wena", wena_o, 0);
    chk("t4_wdata", wdata_o, 32'hdead);

    // 5: flush with a concurrent push drops everything
    commit_ready = 0;
    for (int i = 0; i < 3; i++) begin
      set_push(5'(i + 10), 1'b0, 32'h500 + i, 32'h0, 1'b1);
      step();
    end
    set_push(5'd20, 1'b0, 32'h5ff, 32'h0, 1'b1);
    flush = 1;
    #1;
    chk("t5_ready", ready_pre_o, 0);
    step();
    flush = 0;
    idle();
    chk("t5_count", count_o, 0);
    chk("t5_valid", commit_valid_o, 0);
    commit_ready = 1;
    step();
    chk("t5_nothing", commit_valid_o, 0);

    // 6: full queue with push+pop every cycle keeps occupancy and order
    commit_ready = 0;
    for (int i = 0; i < 4; i++) begin
      set_push(5'(i + 1), 1'b0, 32'h200 + i, 32'h0, 1'b1);
      step();
    end
    commit_ready = 1;
    for (int i = 0; i < 8; i++) begin
      set_push(5'(i + 1), 1'b0, 32'h300 + i, 32'h0, 1'b1);
      step();
      chk("t6_count", count_o, 4);
      chk("t6_order", wdata_o, (i < 4) ? 32'h200 + i : 32'h300 + i - 4);
    end
    idle();
    repeat (5) step();
    chk("t6_drained", empty_o, 1);

    // Reset mid-operation discards queued entries
    commit_ready = 0;
    for (int i = 0; i < 2; i++) begin
      set_push(5'(i + 3), 1'b0, 32'h600 + i, 32'h0, 1'b1);
      step();
    end
    idle();
    reset = 0;
    #1;
    chk("rst_mid_count", count_o, 0);
    chk("rst_mid_wdata", wdata_o, 0);
    step();
    reset = 1;
    commit_ready = 1;
    step(); step();
    chk("rst_mid_novalid", commit_valid_o, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
